// File: rtl/uart_pkg.sv
// Shared definitions for the UART with TX FIFO: register select codes,
// STATUS/CTRL bit positions, FSM state encodings and the parity helper.
package uart_pkg;

  // regSelect decode
  localparam logic [1:0] SEL_TX     = 2'b00;
  localparam logic [1:0] SEL_RX     = 2'b01;
  localparam logic [1:0] SEL_STATUS = 2'b10;
  localparam logic [1:0] SEL_CTRL   = 2'b11;

  // STATUS bit positions; 0..3 read-only, 4..7 sticky write-1-to-clear
  localparam int ST_TXBUSY  = 0;
  localparam int ST_TXFULL  = 1;
  localparam int ST_TXEMPTY = 2;
  localparam int ST_RXVALID = 3;
  localparam int ST_RXOVR   = 4;
  localparam int ST_FERR    = 5;
  localparam int ST_PERR    = 6;
  localparam int ST_TXOVF   = 7;

  // CTRL bit positions; bits 7:4 are not stored and read as zero
  localparam int CT_TXEN = 0;
  localparam int CT_RXEN = 1;
  localparam int CT_RXIE = 2;
  localparam int CT_TXIE = 3;

  localparam logic [3:0] CTRL_RST = 4'h3;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // Parity bit that makes the total number of ones even (odd=0) or odd (odd=1).
  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
// Ports: clk_i, rst_ni (sync, active-low), push_i/wdata_i write side,
// pop_i/rdata_o read side, full_o, empty_o, count_o (0..DEPTH).
// A push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_fifo.sv
// UART with a register interface and a TX FIFO.
// Ports: clk; reset (sync, active-low); writeEnable/readEnable strobes with
// regSelect (00 TXDATA/TXCOUNT, 01 RXDATA, 10 STATUS, 11 CTRL) and writeData;
// Data combinational read data; rx async serial in; tx serial out (idle
// high); irq registered level interrupt.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 104,
  parameter int TX_DEPTH   = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       writeEnable,
  input  logic       readEnable,
  input  logic [1:0] regSelect,
  input  logic [7:0] writeData,
  output logic [7:0] Data,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
  localparam int          CNT_W     = $clog2(TX_DEPTH) + 1;

  logic wr_tx, wr_st, wr_ct, rd_rx;
  assign wr_tx = writeEnable & (regSelect == SEL_TX);
  assign wr_st = writeEnable & (regSelect == SEL_STATUS);
  assign wr_ct = writeEnable & (regSelect == SEL_CTRL);
  assign rd_rx = readEnable  & (regSelect == SEL_RX);

  logic [3:0]       ctrl_q, ctrl_d;
  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             tx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_txfifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (wr_tx),
    .pop_i   (tx_pop),
    .wdata_i (writeData),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------- transmitter ----------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_par_q, tx_par_d;
  logic        tx_q, tx_d;
  logic        tx_go, tx_last, tx_busy;

  assign tx_go   = ~fifo_empty & ctrl_q[CT_TXEN];
  assign tx_last = (tx_cnt_q == DIV_LAST);
  assign tx_busy = (tx_state_q != TX_IDLE);

  // tx is registered: tx_d is the line level for the state being entered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (tx_go) begin
          tx_state_d = TX_START;
          tx_pop     = 1'b1;
          tx_sh_d    = fifo_rdata;
          tx_par_d   = parity_bit(fifo_rdata, PARITY_ODD != 0);
          tx_d       = 1'b0;
        end
      end
      TX_START: if (tx_last) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
        tx_d       = tx_sh_q[0];
      end
      TX_DATA: if (tx_last) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          if (PARITY_EN != 0) begin
            tx_state_d = TX_PARITY;
            tx_d       = tx_par_q;
          end else begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_sh_d  = tx_sh_q >> 1;
          tx_d     = tx_sh_q[1];
        end
      end
      TX_PARITY: if (tx_last) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_STOP;
        tx_d       = 1'b1;
      end
      TX_STOP: if (tx_last) begin
        tx_cnt_d = '0;
        // Back-to-back frames: go straight to START with no idle bit.
        if (tx_go) begin
          tx_state_d = TX_START;
          tx_pop     = 1'b1;
          tx_sh_d    = fifo_rdata;
          tx_par_d   = parity_bit(fifo_rdata, PARITY_ODD != 0);
          tx_d       = 1'b0;
        end else begin
          tx_state_d = TX_IDLE;
          tx_d       = 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // ---------------- receiver ----------------
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_par_q, rx_par_d;
  logic        rx_last, byte_done, ferr_set, perr_set;

  assign rx_last = (rx_cnt_q == DIV_LAST);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    byte_done  = 1'b0;
    ferr_set   = 1'b0;
    perr_set   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q & ~rx_s2_q) rx_state_d = RX_START;
      end
      // Half a bit after the falling edge: a high line means a glitch.
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d = '0;
        if (rx_s2_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          rx_bit_d   = '0;
        end
      end
      RX_DATA: if (rx_last) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) begin
          rx_state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
        end else begin
          rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      RX_PARITY: if (rx_last) begin
        rx_cnt_d   = '0;
        rx_par_d   = rx_s2_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_last) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        if (!rx_s2_q) begin
          ferr_set = 1'b1;
        end else begin
          byte_done = 1'b1;
          perr_set  = (PARITY_EN != 0) &&
                      (rx_par_q != parity_bit(rx_sh_q, PARITY_ODD != 0));
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (!ctrl_q[CT_RXEN]) begin
      rx_state_d = RX_IDLE;
      rx_cnt_d   = '0;
      byte_done  = 1'b0;
      ferr_set   = 1'b0;
      perr_set   = 1'b0;
    end
  end

  // ---------------- registers ----------------
  logic [7:0] rxdata_q, rxdata_d;
  logic       rxvalid_q, rxvalid_d;
  logic       rxovr_q, rxovr_d, ferr_q, ferr_d, perr_q, perr_d, txovf_q, txovf_d;
  logic       irq_q, irq_d;
  logic [7:0] status;

  always_comb begin
    rxdata_d  = rxdata_q;
    rxvalid_d = rxvalid_q;
    rxovr_d   = rxovr_q & ~(wr_st & writeData[ST_RXOVR]);
    ferr_d    = (ferr_q & ~(wr_st & writeData[ST_FERR])) | ferr_set;
    perr_d    = (perr_q & ~(wr_st & writeData[ST_PERR])) | perr_set;
    txovf_d   = (txovf_q & ~(wr_st & writeData[ST_TXOVF])) |
                (wr_tx & fifo_full & ~tx_pop);
    // A read of RXDATA in the arrival cycle frees the slot for the new byte.
    if (byte_done) begin
      if (rxvalid_q & ~rd_rx) begin
        rxovr_d = 1'b1;
      end else begin
        rxdata_d  = rx_sh_q;
        rxvalid_d = 1'b1;
      end
    end else if (rd_rx) begin
      rxvalid_d = 1'b0;
    end
    ctrl_d = wr_ct ? writeData[3:0] : ctrl_q;
    irq_d  = (ctrl_q[CT_RXIE] & rxvalid_q) |
             (ctrl_q[CT_TXIE] & fifo_empty & ~tx_busy);
  end

  always_comb begin
    status             = '0;
    status[ST_TXBUSY]  = tx_busy;
    status[ST_TXFULL]  = fifo_full;
    status[ST_TXEMPTY] = fifo_empty;
    status[ST_RXVALID] = rxvalid_q;
    status[ST_RXOVR]   = rxovr_q;
    status[ST_FERR]    = ferr_q;
    status[ST_PERR]    = perr_q;
    status[ST_TXOVF]   = txovf_q;
  end

  always_comb begin
    Data = 8'h00;
    if (readEnable) begin
      case (regSelect)
        SEL_TX:     Data = 8'(fifo_count);
        SEL_RX:     Data = rxdata_q;
        SEL_STATUS: Data = status;
        SEL_CTRL:   Data = {4'b0000, ctrl_q};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rxdata_q   <= '0;
      rxvalid_q  <= 1'b0;
      rxovr_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      txovf_q    <= 1'b0;
      ctrl_q     <= CTRL_RST;
      irq_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rxdata_q   <= rxdata_d;
      rxvalid_q  <= rxvalid_d;
      rxovr_q    <= rxovr_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      txovf_q    <= txovf_d;
      ctrl_q     <= ctrl_d;
      irq_q      <= irq_d;
    end
  end

  // Shift registers and parity holders only matter inside a frame.
  always_ff @(posedge clk) begin
    tx_sh_q  <= tx_sh_d;
    tx_par_q <= tx_par_d;
    rx_sh_q  <= rx_sh_d;
    rx_par_q <= rx_par_d;
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: a table of register-level vectors, then directed
// multi-cycle sequences for TX framing, RX framing, parity and reset.
module tb_uart_fifo;

  logic       clk = 1'b0;
  logic       reset, writeEnable, readEnable, rx;
  logic [1:0] regSelect;
  logic [7:0] writeData;
  logic [7:0] Data, Data_p;
  logic       tx, tx_p, irq, irq_p;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_fifo #(.CLK_DIV(16), .TX_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clk(clk), .reset(reset), .writeEnable(writeEnable), .readEnable(readEnable),
    .regSelect(regSelect), .writeData(writeData), .Data(Data), .rx(rx),
    .tx(tx), .irq(irq)
  );

  uart_fifo #(.CLK_DIV(16), .TX_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1)) u_dutp (
    .clk(clk), .reset(reset), .writeEnable(writeEnable), .readEnable(readEnable),
    .regSelect(regSelect), .writeData(writeData), .Data(Data_p), .rx(rx),
    .tx(tx_p), .irq(irq_p)
  );

  typedef struct {
    logic       we;
    logic       re;
    logic [1:0] sel;
    logic [7:0] wd;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [18];
  logic [7:0] exp_bytes [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic peek(input logic [1:0] sel, output logic [7:0] d, output logic [7:0] dp);
    readEnable = 1'b1;
    regSelect  = sel;
    #1;
    d  = Data;
    dp = Data_p;
    readEnable = 1'b0;
  endtask

  task automatic reg_wr(input logic [1:0] sel, input logic [7:0] d);
    writeEnable = 1'b1;
    regSelect   = sel;
    writeData   = d;
    tick();
    writeEnable = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; writeEnable = 1'b0; readEnable = 1'b0;
    regSelect = 2'b00; writeData = 8'h00; rx = 1'b1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Waits (bounded) for the start bit, then checks every clock of nfr
  // frames against exp_bytes, 16 clocks per bit.
  task automatic check_tx_stream(input int nfr, input logic chk_busy, input logic [7:0] st_after);
    int k;
    logic [7:0] d, dp;
    k = 0;
    while (tx == 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check("tx_start_found", {7'b0, tx}, 8'h00);
    for (int f = 0; f < nfr; f++)
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < 16; c++) begin
          check($sformatf("tx_f%0d_b%0d_c%0d", f, b, c), {7'b0, tx},
                {7'b0, frame_bit(exp_bytes[f], b)});
          if (chk_busy) begin
            peek(2'b10, d, dp);
            check("txbusy_in_frame", {7'b0, d[0]}, 8'h01);
          end
          tick();
        end
    check("tx_idle_high", {7'b0, tx}, 8'h01);
    peek(2'b10, d, dp);
    check("status_after_tx", d, st_after);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par,
                            input logic par, input logic stop);
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) tick();
    end
    if (use_par) begin
      rx = par;
      repeat (16) tick();
    end
    rx = stop;
    repeat (16) tick();
    rx = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, dp;

    //         we re sel    wd     chk exp
    vecs[0]  = '{0, 1, 2'b10, 8'h00, 1, 8'h04};  // STATUS after reset
    vecs[1]  = '{0, 1, 2'b11, 8'h00, 1, 8'h03};  // CTRL after reset
    vecs[2]  = '{0, 1, 2'b01, 8'h00, 1, 8'h00};  // RXDATA after reset
    vecs[3]  = '{0, 1, 2'b00, 8'h00, 1, 8'h00};  // TX count after reset
    vecs[4]  = '{0, 0, 2'b11, 8'h00, 1, 8'h00};  // no read strobe -> 0
    vecs[5]  = '{1, 0, 2'b11, 8'hF2, 0, 8'h00};  // CTRL: rxen only, reserved ignored
    vecs[6]  = '{0, 1, 2'b11, 8'h00, 1, 8'h02};
    vecs[7]  = '{1, 0, 2'b00, 8'h11, 0, 8'h00};
    vecs[8]  = '{0, 1, 2'b00, 8'h00, 1, 8'h01};
    vecs[9]  = '{1, 0, 2'b00, 8'h22, 0, 8'h00};
    vecs[10] = '{1, 0, 2'b00, 8'h33, 0, 8'h00};
    vecs[11] = '{1, 0, 2'b00, 8'h44, 0, 8'h00};
    vecs[12] = '{0, 1, 2'b10, 8'h00, 1, 8'h02};  // full, not empty, idle
    vecs[13] = '{1, 0, 2'b00, 8'h55, 0, 8'h00};  // dropped push
    vecs[14] = '{0, 1, 2'b10, 8'h00, 1, 8'h82};  // txovf set
    vecs[15] = '{0, 1, 2'b00, 8'h00, 1, 8'h04};
    vecs[16] = '{1, 0, 2'b10, 8'hFF, 0, 8'h00};  // W1C all; low bits read-only
    vecs[17] = '{0, 1, 2'b10, 8'h00, 1, 8'h02};

    do_reset();
    check("tx_reset", {7'b0, tx}, 8'h01);
    check("tx_p_reset", {7'b0, tx_p}, 8'h01);
    check("irq_reset", {7'b0, irq}, 8'h00);
    check("irq_p_reset", {7'b0, irq_p}, 8'h00);

    for (int i = 0; i < 18; i++) begin
      writeEnable = vecs[i].we;
      readEnable  = vecs[i].re;
      regSelect   = vecs[i].sel;
      writeData   = vecs[i].wd;
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d", i), Data, vecs[i].exp);
      tick();
      writeEnable = 1'b0;
      readEnable  = 1'b0;
    end

    // irq from txie with empty FIFO and idle TX, one cycle behind CTRL
    do_reset();
    reg_wr(2'b11, 8'h0B);
    check("irq_latency_0", {7'b0, irq}, 8'h00);
    tick();
    check("irq_txie", {7'b0, irq}, 8'h01);

    // Single frame 8'hA5
    do_reset();
    reg_wr(2'b00, 8'hA5);
    exp_bytes[0] = 8'hA5;
    check_tx_stream(1, 1'b1, 8'h04);

    // Five writes with txen off, then four back-to-back frames
    do_reset();
    reg_wr(2'b11, 8'h02);
    reg_wr(2'b00, 8'h11);
    reg_wr(2'b00, 8'h22);
    reg_wr(2'b00, 8'h33);
    reg_wr(2'b00, 8'h44);
    reg_wr(2'b00, 8'h55);
    peek(2'b10, d, dp);
    check("burst_status", d, 8'h82);
    peek(2'b00, d, dp);
    check("burst_count", d, 8'h04);
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22;
    exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h44;
    reg_wr(2'b11, 8'h03);
    check_tx_stream(4, 1'b0, 8'h84);

    // RX: good frame, then overrun
    do_reset();
    reg_wr(2'b11, 8'h07);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    peek(2'b01, d, dp);
    check("rx_data", d, 8'h3C);
    peek(2'b10, d, dp);
    check("rx_status", d, 8'h0C);
    check("irq_rxie", {7'b0, irq}, 8'h01);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    peek(2'b10, d, dp);
    check("rx_ovr_status", d, 8'h1C);
    peek(2'b01, d, dp);
    check("rx_ovr_data", d, 8'h3C);
    readEnable = 1'b1; regSelect = 2'b01;
    tick();
    readEnable = 1'b0;
    peek(2'b10, d, dp);
    check("rx_read_clears", d, 8'h14);
    reg_wr(2'b10, 8'h10);
    peek(2'b10, d, dp);
    check("rxovr_w1c", d, 8'h04);

    // RX: glitch, then framing error
    do_reset();
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (40) tick();
    peek(2'b10, d, dp);
    check("glitch_status", d, 8'h04);
    peek(2'b01, d, dp);
    check("glitch_data", d, 8'h00);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    peek(2'b10, d, dp);
    check("ferr_status", d, 8'h24);
    peek(2'b01, d, dp);
    check("ferr_data", d, 8'h00);

    // Odd parity on the second instance
    do_reset();
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    repeat (2) tick();
    peek(2'b10, d, dp);
    check("perr_status", dp, 8'h4C);
    peek(2'b01, d, dp);
    check("perr_data", dp, 8'h01);
    reg_wr(2'b10, 8'h40);
    peek(2'b10, d, dp);
    check("perr_w1c", dp, 8'h0C);
    readEnable = 1'b1; regSelect = 2'b01;
    tick();
    readEnable = 1'b0;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    repeat (2) tick();
    peek(2'b10, d, dp);
    check("par_ok_status", dp, 8'h0C);
    peek(2'b01, d, dp);
    check("par_ok_data", dp, 8'h03);

    // Reset in the middle of a frame
    do_reset();
    reg_wr(2'b11, 8'h0F);
    reg_wr(2'b00, 8'h5A);
    reg_wr(2'b00, 8'h77);
    repeat (40) tick();
    peek(2'b10, d, dp);
    check("busy_before_reset", {7'b0, d[0]}, 8'h01);
    reset = 1'b0;
    tick();
    check("reset_tx", {7'b0, tx}, 8'h01);
    peek(2'b10, d, dp);
    check("reset_status", d, 8'h04);
    peek(2'b11, d, dp);
    check("reset_ctrl", d, 8'h03);
    check("reset_irq", {7'b0, irq}, 8'h00);
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
